// File: rtl/cpu_axi_bridge.sv
// Bridges cpu_core's SRAM-like inst/data ports onto one AXI master.
// Inst and data reads share AR (data first); data stores use AW/W/B.
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE, AR_REQ} ar_state_t;
  typedef enum logic {W_IDLE, W_REQ} w_state_t;

  ar_state_t ar_state;
  w_state_t  w_state;
  logic      inst_pend;
  logic      data_pend;
  logic      data_rd_ok;
  logic      data_wr_ok;
  logic      r_inst;
  logic      r_data;
  logic      b_data;

  // Request acceptance; one outstanding transaction per port keeps loads behind stores.
  assign data_rd_ok = !reset && data_sram_req && !data_sram_wr && !data_pend && (ar_state == AR_IDLE);
  assign data_wr_ok = !reset && data_sram_req && data_sram_wr && !data_pend && (w_state == W_IDLE);
  assign data_sram_addr_ok = data_rd_ok || data_wr_ok;
  assign inst_sram_addr_ok = !reset && inst_sram_req && !inst_pend && (ar_state == AR_IDLE) && !data_rd_ok;

  assign r_inst = rvalid && rready && (rid == INST_ID);
  assign r_data = rvalid && rready && (rid == DATA_ID);
  assign b_data = bvalid && bready;

  // AR channel: data read wins over instruction fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
      araddr   <= 32'd0;
      arid     <= 4'd0;
      arsize   <= 3'd0;
    end else if (ar_state == AR_IDLE) begin
      if (data_rd_ok) begin
        ar_state <= AR_REQ;
        arvalid  <= 1'b1;
        araddr   <= data_sram_addr;
        arid     <= DATA_ID;
        arsize   <= {1'b0, data_sram_size};
      end else if (inst_sram_addr_ok) begin
        ar_state <= AR_REQ;
        arvalid  <= 1'b1;
        araddr   <= inst_sram_addr;
        arid     <= INST_ID;
        arsize   <= {1'b0, inst_sram_size};
      end
    end else if (arready) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
    end
  end

  // AW and W handshake independently; the FSM idles once both are done.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= 32'd0;
      awsize  <= 3'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
    end else if (w_state == W_IDLE) begin
      if (data_wr_ok) begin
        w_state <= W_REQ;
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        awaddr  <= data_sram_addr;
        awsize  <= {1'b0, data_sram_size};
        wdata   <= data_sram_wdata;
        wstrb   <= data_sram_wstrb;
      end
    end else begin
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready) wvalid <= 1'b0;
      if ((!awvalid || awready) && (!wvalid || wready)) w_state <= W_IDLE;
    end
  end

  // Response routing by rid / B, pending tracking and registered data_ok pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rready            <= 1'b0;
      bready            <= 1'b0;
      inst_pend         <= 1'b0;
      data_pend         <= 1'b0;
      inst_sram_data_ok <= 1'b0;
      data_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= 32'd0;
      data_sram_rdata   <= 32'd0;
    end else begin
      rready            <= 1'b1;
      bready            <= 1'b1;
      inst_sram_data_ok <= r_inst && inst_pend;
      data_sram_data_ok <= (r_data || b_data) && data_pend;
      if (r_inst && inst_pend) inst_sram_rdata <= rdata;
      if (r_data && data_pend) data_sram_rdata <= rdata;
      if (inst_sram_addr_ok) inst_pend <= 1'b1;
      else if (r_inst) inst_pend <= 1'b0;
      if (data_sram_addr_ok) data_pend <= 1'b1;
      else if (r_data || b_data) data_pend <= 1'b0;
    end
  end

  // A response without a matching outstanding request is a slave protocol error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(r_inst && !inst_pend));
      assert (!(r_data && !data_pend));
      assert (!(b_data && !data_pend));
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: inputs change on the falling edge, outputs checked 1 time unit later.
module tb_cpu_axi_bridge;

  logic        clk;
  logic        reset;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int passed;
  int total;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total++; if (arvalid !== 1'b0) $display("FAIL rst_arvalid got %b want 0", arvalid); else passed++;
    total++; if (awvalid !== 1'b0 || wvalid !== 1'b0) $display("FAIL rst_awvalid_wvalid got %b%b want 00", awvalid, wvalid); else passed++;
    total++; if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) $display("FAIL rst_data_ok got %b%b want 00", inst_sram_data_ok, data_sram_data_ok); else passed++;
    total++; if (rready !== 1'b0 || bready !== 1'b0) $display("FAIL rst_ready got %b%b want 00", rready, bready); else passed++;
    total++; if (araddr !== 32'd0 || inst_sram_rdata !== 32'd0 || data_sram_rdata !== 32'd0) $display("FAIL rst_payload got %h %h %h want 0", araddr, inst_sram_rdata, data_sram_rdata); else passed++;
    reset = 1'b0;
    @(negedge clk); #1;
    total++; if (rready !== 1'b1 || bready !== 1'b1) $display("FAIL post_rst_ready got %b%b want 11", rready, bready); else passed++;
  endtask

  task automatic test_inst_fetch();
    @(negedge clk);
    inst_sram_req = 1'b1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1c000000; arready = 1'b1;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1) $display("FAIL fetch_addr_ok got %b want 1", inst_sram_addr_ok); else passed++;
    @(negedge clk);
    inst_sram_req = 1'b0;
    #1;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h1c000000 || arid !== 4'd0 || arsize !== 3'd2)
      $display("FAIL fetch_ar got v=%b a=%h id=%h s=%0d want v=1 a=1c000000 id=0 s=2", arvalid, araddr, arid, arsize); else passed++;
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h02800c0c;
    #1;
    total++; if (arvalid !== 1'b0 || inst_sram_data_ok !== 1'b0) $display("FAIL fetch_t2 got arvalid=%b data_ok=%b want 0 0", arvalid, inst_sram_data_ok); else passed++;
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h02800c0c) $display("FAIL fetch_data got ok=%b rdata=%h want 1 02800c0c", inst_sram_data_ok, inst_sram_rdata); else passed++;
    @(negedge clk); #1;
    total++; if (inst_sram_data_ok !== 1'b0) $display("FAIL fetch_pulse got %b want 0", inst_sram_data_ok); else passed++;
  endtask

  task automatic test_priority();
    @(negedge clk);
    arready = 1'b0;
    inst_sram_req = 1'b1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1c000010;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = 2'd2; data_sram_addr = 32'h1c001000;
    #1;
    total++; if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) $display("FAIL prio_accept got d=%b i=%b want 1 0", data_sram_addr_ok, inst_sram_addr_ok); else passed++;
    @(negedge clk);
    data_sram_req = 1'b0;
    #1;
    total++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h1c001000 || inst_sram_addr_ok !== 1'b0)
      $display("FAIL prio_data_ar got v=%b id=%h a=%h iok=%b want 1 1 1c001000 0", arvalid, arid, araddr, inst_sram_addr_ok); else passed++;
    arready = 1'b1;
    @(negedge clk); #1;
    total++; if (arvalid !== 1'b0 || inst_sram_addr_ok !== 1'b1) $display("FAIL prio_inst_accept got v=%b iok=%b want 0 1", arvalid, inst_sram_addr_ok); else passed++;
    @(negedge clk);
    inst_sram_req = 1'b0;
    #1;
    total++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1c000010) $display("FAIL prio_inst_ar got v=%b id=%h a=%h want 1 0 1c000010", arvalid, arid, araddr); else passed++;
  endtask

  task automatic test_out_of_order();
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd5; rdata = 32'hbad0bad0;
    @(negedge clk);
    rid = 4'd1; rdata = 32'h11112222;
    #1;
    total++; if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) $display("FAIL ooo_bad_rid got %b%b want 00", inst_sram_data_ok, data_sram_data_ok); else passed++;
    @(negedge clk);
    rid = 4'd0; rdata = 32'h33334444;
    #1;
    total++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'h11112222 || inst_sram_data_ok !== 1'b0)
      $display("FAIL ooo_data_first got d=%b rd=%h i=%b want 1 11112222 0", data_sram_data_ok, data_sram_rdata, inst_sram_data_ok); else passed++;
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h33334444 || data_sram_data_ok !== 1'b0)
      $display("FAIL ooo_inst_second got i=%b rd=%h d=%b want 1 33334444 0", inst_sram_data_ok, inst_sram_rdata, data_sram_data_ok); else passed++;
  endtask

  task automatic test_store_then_load();
    @(negedge clk);
    wready = 1'b1; awready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2; data_sram_addr = 32'h1c008000;
    data_sram_wdata = 32'hdeadbeef; data_sram_wstrb = 4'b0011;
    #1;
    total++; if (data_sram_addr_ok !== 1'b1) $display("FAIL st_accept got %b want 1", data_sram_addr_ok); else passed++;
    @(negedge clk);
    data_sram_req = 1'b0;
    #1;
    total++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h1c008000 || awsize !== 3'd2 || wdata !== 32'hdeadbeef || wstrb !== 4'b0011)
      $display("FAIL st_aw_w got av=%b wv=%b a=%h s=%0d d=%h b=%b", awvalid, wvalid, awaddr, awsize, wdata, wstrb); else passed++;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1c008000;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) awready = 1'b1;
      #1;
      total++; if (wvalid !== 1'b0 || awvalid !== 1'b1 || data_sram_addr_ok !== 1'b0)
        $display("FAIL st_hold_t%0d got wv=%b av=%b dok=%b want 0 1 0", c, wvalid, awvalid, data_sram_addr_ok); else passed++;
    end
    @(negedge clk);
    awready = 1'b0; bvalid = 1'b1;
    #1;
    total++; if (awvalid !== 1'b0 || data_sram_addr_ok !== 1'b0 || data_sram_data_ok !== 1'b0)
      $display("FAIL st_b_cycle got av=%b aok=%b dok=%b want 0 0 0", awvalid, data_sram_addr_ok, data_sram_data_ok); else passed++;
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    total++; if (data_sram_data_ok !== 1'b1 || data_sram_addr_ok !== 1'b1) $display("FAIL st_done_ld_accept got ok=%b aok=%b want 1 1", data_sram_data_ok, data_sram_addr_ok); else passed++;
    @(negedge clk);
    data_sram_req = 1'b0;
    #1;
    total++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h1c008000 || data_sram_data_ok !== 1'b0)
      $display("FAIL ld_ar got v=%b id=%h a=%h ok=%b", arvalid, arid, araddr, data_sram_data_ok); else passed++;
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000beef;
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    total++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'h0000beef) $display("FAIL ld_data got ok=%b rd=%h want 1 0000beef", data_sram_data_ok, data_sram_rdata); else passed++;
  endtask

  task automatic test_dual_response();
    @(negedge clk);
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000020; inst_sram_size = 2'd2;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1c008004;
    data_sram_wdata = 32'h01234567; data_sram_wstrb = 4'b1111;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b1) $display("FAIL dual_accept got i=%b d=%b want 1 1", inst_sram_addr_ok, data_sram_addr_ok); else passed++;
    @(negedge clk);
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h55667788; bvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; bvalid = 1'b0;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h55667788)
      $display("FAIL dual_ok got i=%b d=%b rd=%h want 1 1 55667788", inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata); else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000030;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1c008008;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (arvalid !== 1'b1 || awvalid !== 1'b1) $display("FAIL mid_pre got av=%b awv=%b want 1 1", arvalid, awvalid); else passed++;
    @(negedge clk); #1;
    total++; if (arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0) $display("FAIL mid_valids got %b%b%b want 000", arvalid, awvalid, wvalid); else passed++;
    total++; if (inst_sram_addr_ok !== 1'b0 || data_sram_addr_ok !== 1'b0 || inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0)
      $display("FAIL mid_oks got %b%b%b%b want 0000", inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok); else passed++;
    reset = 1'b0; inst_sram_req = 1'b0; data_sram_req = 1'b0;
    @(negedge clk);
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000040;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1c00800c;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b1) $display("FAIL mid_fresh_accept got i=%b d=%b want 1 1", inst_sram_addr_ok, data_sram_addr_ok); else passed++;
    @(negedge clk);
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    #1;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h1c000040 || awaddr !== 32'h1c00800c) $display("FAIL mid_fresh_ar got v=%b a=%h aw=%h", arvalid, araddr, awaddr); else passed++;
    @(negedge clk);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'ha5a5a5a5; bvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; bvalid = 1'b0;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'ha5a5a5a5 || data_sram_data_ok !== 1'b1)
      $display("FAIL mid_fresh_done got i=%b rd=%h d=%b want 1 a5a5a5a5 1", inst_sram_data_ok, inst_sram_rdata, data_sram_data_ok); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_size = 2'd0; inst_sram_addr = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0; data_sram_addr = 32'd0;
    data_sram_wstrb = 4'd0; data_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    test_reset();
    test_inst_fetch();
    test_priority();
    test_out_of_order();
    test_store_then_load();
    test_dual_response();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
